ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 28 ++
 rtl/ram_arb_pick.sv | 40 ++++
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared defines header and package for the RAM arbiter: bus widths, FSM state encodings, index helper.
// Round-robin granting is enabled by defining RAM_ARB_RR_EN; fixed priority otherwise.
`ifndef RAM_ARBITER_DEFINES
`define RAM_ARBITER_DEFINES
`define RAM_ADDR_BUS      8
`define RAM_DATA_BUS      8
`define RAM_ARB_ST_IDLE   2'd0
`define RAM_ARB_ST_ACCESS 2'd1
`define RAM_ARB_ST_RESP   2'd2
`endif

package ram_arbiter_pkg;

    localparam int AW = `RAM_ADDR_BUS;
    localparam int DW = `RAM_DATA_BUS;

    typedef enum logic [1:0] {
        ST_IDLE   = `RAM_ARB_ST_IDLE,
        ST_ACCESS = `RAM_ARB_ST_ACCESS,
        ST_RESP   = `RAM_ARB_ST_RESP
    } state_e;

    // Requester index reached by stepping 'off' places from 'base' in a ring of n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selector: one-hot grant plus index of the chosen requester.
// With RAM_ARB_RR_EN the search starts at ptr; otherwise the lowest valid index wins.
module ram_arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_any
);

`ifndef RAM_ARB_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
`ifdef RAM_ARB_RR_EN
            idx = wrap_idx(int'(ptr), k, N_REQ);
`else
            idx = k;
`endif
            if (!grant_any && valid[idx]) begin
                grant_any     = 1'b1;
                grant_idx     = IW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: one transaction in flight, IDLE -> ACCESS -> RESP -> IDLE.
// Grant policy is fixed priority unless RAM_ARB_RR_EN selects round-robin.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_we,
    input  logic [N_REQ*`RAM_ADDR_BUS-1:0] req_addr,
    input  logic [N_REQ*`RAM_DATA_BUS-1:0] req_wdata,
    output logic [N_REQ-1:0]               resp_valid,
    input  logic [N_REQ-1:0]               resp_ready,
    output logic [`RAM_DATA_BUS-1:0]       resp_rdata,
    output logic [`RAM_ADDR_BUS-1:0]       ram_addr,
    output logic                           ram_wr_en,
    output logic                           ram_rd_en,
    output logic [`RAM_DATA_BUS-1:0]       ram_wdata,
    input  logic [`RAM_DATA_BUS-1:0]       ram_rdata,
    output logic                           busy
);

    localparam int IW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] grant_oh;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;

`ifdef RAM_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    ram_arb_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        // NOTE: every next-state and output gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        gidx_d     = gidx_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef RAM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        req_ready  = '0;
        resp_valid = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_wr_en  = 1'b0;
        ram_rd_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready = grant_oh;
                    gidx_d    = grant_idx;
                    we_d      = req_we[grant_idx];
                    addr_d    = req_addr[grant_idx*AW +: AW];
                    wdata_d   = req_wdata[grant_idx*DW +: DW];
                    state_d   = ST_ACCESS;
`ifdef RAM_ARB_RR_EN
                    ptr_d     = IW'(wrap_idx(int'(grant_idx), 1, N_REQ));
`endif
                end
            end
            ST_ACCESS: begin
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ram_wr_en = we_q;
                ram_rd_en = !we_q;
                rdata_d   = we_q ? '0 : ram_rdata;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[gidx_q] = 1'b1;
                if (resp_ready[gidx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset aborts in-flight work: a pending write must not reach the RAM this cycle.
        if (rst) begin
            req_ready  = '0;
            resp_valid = '0;
            ram_wr_en  = 1'b0;
            ram_rd_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign resp_rdata = rdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
